// File: rtl/vector_pkg.sv
// Shared types and screen constants for the cursor/click front end.
package vector_pkg;

  typedef enum logic [1:0] {ARMED, COOLDOWN, WAIT_RELEASE} click_state_t;

  localparam int SCREEN_MIN = 0;
  localparam int SCREEN_MAX = 255;

endpackage

// File: rtl/cursor_axis.sv
// One cursor axis: scale the delta, add it to the position, clamp, and register.
module cursor_axis
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH   = 8,
  parameter int DELTA_WIDTH = 9,
  parameter int SHIFT       = 1,
  parameter int MIN         = SCREEN_MIN,
  parameter int MAX         = SCREEN_MAX,
  parameter int RESET       = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [DELTA_WIDTH-1:0] delta,
  input  logic                   recenter,
  output logic [OUT_WIDTH-1:0]   cursor
);

  // Wide enough that no 8-bit position plus 9-bit delta can overflow.
  localparam int SW = OUT_WIDTH + DELTA_WIDTH + 1;
  localparam logic signed [SW-1:0] MIN_S = SW'(MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

  logic signed [DELTA_WIDTH-1:0] d;
  logic signed [SW-1:0]          d_ext;
  logic signed [SW-1:0]          cur_ext;
  logic signed [SW-1:0]          sum;
  logic [OUT_WIDTH-1:0]          nxt;

  assign d       = $signed(delta) >>> SHIFT;
  assign d_ext   = {{(SW-DELTA_WIDTH){d[DELTA_WIDTH-1]}}, d};
  assign cur_ext = {{(SW-OUT_WIDTH){1'b0}}, cursor};
  assign sum     = cur_ext + d_ext;

  // Saturate at the axis bounds instead of wrapping.
  always_comb begin
    nxt = sum[OUT_WIDTH-1:0];
    if (sum < MIN_S)      nxt = OUT_WIDTH'(MIN);
    else if (sum > MAX_S) nxt = OUT_WIDTH'(MAX);
  end

  // Position register; recenter wins over a same-cycle packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cursor <= OUT_WIDTH'(RESET);
    else if (recenter) cursor <= OUT_WIDTH'(RESET);
    else if (valid)    cursor <= nxt;
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Mouse packets -> absolute cursor plus a rate-limited one-cycle fire pulse.
module cursor_ctrl
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH       = 8,
  parameter int DELTA_WIDTH     = 9,
  parameter int SHIFT           = 1,
  parameter int X_MIN           = SCREEN_MIN,
  parameter int X_MAX           = SCREEN_MAX,
  parameter int Y_MIN           = SCREEN_MIN,
  parameter int Y_MAX           = SCREEN_MAX,
  parameter int X_RESET         = 128,
  parameter int Y_RESET         = 128,
  parameter int COOLDOWN_CYCLES = 20_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mouse_valid,
  input  logic [DELTA_WIDTH-1:0] mouse_dx,
  input  logic [DELTA_WIDTH-1:0] mouse_dy,
  input  logic                   mouse_left,
  input  logic                   enable,
  input  logic                   recenter,
  output logic [OUT_WIDTH-1:0]   xcursor,
  output logic [OUT_WIDTH-1:0]   ycursor,
  output logic                   button_click,
  output logic                   cooldown_busy
);

  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  click_state_t  state;
  logic [CW-1:0] cnt;
  logic          left_q;

  cursor_axis #(
    .OUT_WIDTH(OUT_WIDTH), .DELTA_WIDTH(DELTA_WIDTH), .SHIFT(SHIFT),
    .MIN(X_MIN), .MAX(X_MAX), .RESET(X_RESET)
  ) u_x (
    .clk(clk), .rst(rst), .valid(mouse_valid), .delta(mouse_dx),
    .recenter(recenter), .cursor(xcursor)
  );

  // Positive dy moves the cursor up, i.e. toward larger y.
  cursor_axis #(
    .OUT_WIDTH(OUT_WIDTH), .DELTA_WIDTH(DELTA_WIDTH), .SHIFT(SHIFT),
    .MIN(Y_MIN), .MAX(Y_MAX), .RESET(Y_RESET)
  ) u_y (
    .clk(clk), .rst(rst), .valid(mouse_valid), .delta(mouse_dy),
    .recenter(recenter), .cursor(ycursor)
  );

  // Click FSM: fire on a press when armed, lock out for the cooldown, and
  // require a release before re-arming if the button is still held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ARMED;
      cnt           <= '0;
      left_q        <= 1'b0;
      button_click  <= 1'b0;
      cooldown_busy <= 1'b0;
    end else begin
      button_click <= 1'b0;
      if (mouse_valid) left_q <= mouse_left;
      case (state)
        ARMED: begin
          if (mouse_valid && mouse_left && enable) begin
            button_click  <= 1'b1;
            cooldown_busy <= 1'b1;
            cnt           <= CW'(COOLDOWN_CYCLES - 1);
            state         <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cnt == '0) begin
            cooldown_busy <= 1'b0;
            state         <= left_q ? WAIT_RELEASE : ARMED;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (mouse_valid && !mouse_left) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Converts raw mouse packets (signed 9-bit deltas plus left-button level) into the absolute 8-bit cursor coordinates and the one-cycle `button_click` fire pulse consumed by `top_rtl`. Sits directly upstream of `top_rtl`, between the PS/2 mouse receiver and the game logic, in the `clk_fast` domain. Deltas are scaled, accumulated with per-axis saturation, and the click is rate-limited by a cooldown FSM.

## Interface
- `OUT_WIDTH`, 8: cursor coordinate width.
- `DELTA_WIDTH`, 9: mouse delta width, two's complement.
- `SHIFT`, 1: arithmetic right-shift applied to each delta (sensitivity divider).
- `X_MIN`/`X_MAX`, 0/255: x clamp bounds, inclusive.
- `Y_MIN`/`Y_MAX`, 0/255: y clamp bounds, inclusive.
- `X_RESET`/`Y_RESET`, 128/128: cursor value after reset and on `recenter`.
- `COOLDOWN_CYCLES`, 20_000_000: minimum spacing between fire pulses, in cycles.

- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-low reset.
- `mouse_valid` in 1: one-cycle strobe, new packet on `mouse_dx/dy/left`.
- `mouse_dx` in DELTA_WIDTH: signed x delta, valid with strobe.
- `mouse_dy` in DELTA_WIDTH: signed y delta, positive = up, valid with strobe.
- `mouse_left` in 1: left-button level, valid with strobe.
- `enable` in 1: game running; clicks suppressed when low.
- `recenter` in 1: one-cycle request, cursor to reset position.
- `xcursor` out OUT_WIDTH: absolute x.
- `ycursor` out OUT_WIDTH: absolute y.
- `button_click` out 1: one-cycle fire pulse.
- `cooldown_busy` out 1: high while fire is locked out.

## Operation
- Reset (`rst`=0, async): `xcursor`=X_RESET, `ycursor`=Y_RESET, `button_click`=0, `cooldown_busy`=0, FSM=ARMED, counter=0, `left_q`=0.
- Axis update on `mouse_valid`: `d = delta >>> SHIFT` (sign-preserving); `sum = cursor + d` computed signed in OUT_WIDTH+DELTA_WIDTH+1 bits; result clamped to [MIN,MAX] per axis. No wrap-around at any delta.
- `recenter` has priority over `mouse_valid` in the same cycle; that packet's deltas are dropped, its button level is still processed.
- `left_q` <= `mouse_left` on every `mouse_valid`.
- Click FSM states:
  - ARMED: if `mouse_valid & mouse_left & enable` -> `button_click`=1 next cycle, load counter = COOLDOWN_CYCLES-1, go COOLDOWN.
  - COOLDOWN: `cooldown_busy`=1; decrement each cycle; at 0 -> WAIT_RELEASE if `left_q`=1 else ARMED. Packets ignored for firing; `enable` deassert does not abort.
  - WAIT_RELEASE: `cooldown_busy`=0; leave to ARMED on a packet with `mouse_left`=0. Holding the button never auto-fires.
- `enable`=0: cursor still tracks; ARMED does not fire.
- Reset mid-cooldown: returns to ARMED immediately, counter cleared.

## Timing
- Packet at cycle N -> `xcursor`/`ycursor` updated at edge ending N, visible in N+1 (latency 1).
- Fire packet at N -> `button_click` high exactly in N+1; `cooldown_busy` high cycles N+1 .. N+COOLDOWN_CYCLES; earliest next fire packet N+COOLDOWN_CYCLES+1 (button released between).
- All outputs registered; no combinational input-to-output path.
- Back-to-back `mouse_valid` on consecutive cycles supported; each packet accumulated.

## Structure
- `vector_pkg` gains: `typedef enum logic [1:0] {ARMED, COOLDOWN, WAIT_RELEASE} click_state_t`; screen bounds constants `SCREEN_MIN`/`SCREEN_MAX` used as parameter defaults.
- One sub-module, `cursor_axis`: scale, signed add, clamp, register; instantiated twice (x, y) with its own MIN/MAX/RESET.
- Counter width `$clog2(COOLDOWN_CYCLES)`; FSM and counter in `cursor_ctrl`.

## Test plan
- Reset, then packet dx=+20, dy=-10, SHIFT=1 -> x=138, y=123 one cycle after strobe.
- x=250, packet dx=+100 -> x=255; x=3, packet dx=-256 -> x=0; no wrap.
- `enable`=1, packet left=1 at N -> `button_click` only in N+1; second left=1 packet during cooldown -> no pulse; `cooldown_busy` falls after COOLDOWN_CYCLES (bench uses 16).
- Button held through cooldown -> no fire until a left=0 packet, then left=1 packet fires.
- `enable`=0, left=1 packet -> no pulse, cursor still moves; `recenter` with simultaneous dx=+50 -> x=128.
- `rst` low mid-cooldown with x=200 -> asynchronously x=128, `cooldown_busy`=0; next left=1 packet fires immediately.
